// File: rtl/jbi_sc_req_pkg.sv
// Shared types and default sizing for the JBI-to-sctag request sequencer.
package jbi_sc_req_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HDR_HI    = 3'd1,
    HDR_LO    = 3'd2,
    WR_DATA   = 3'd3,
    POR_DRAIN = 3'd4
  } req_state_e;

  localparam int HDR_BEATS     = 2;
  localparam int IQ_DEPTH_DEF  = 16;
  localparam int WIB_DEPTH_DEF = 4;
  localparam int WR_BEATS_DEF  = 16;

endpackage

// File: rtl/jbi_sc_credit_cnt.sv
// Saturating credit counter: resets full, dec on consume, inc on return, sticky overflow.
module jbi_sc_credit_cnt #(
  parameter int DEPTH = 4,
  localparam int W = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         overflow_o
);

  localparam logic [W-1:0] FULL = W'(DEPTH);

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    // A simultaneous return and consume cancel out, even at full.
    if (inc_i && !dec_i) begin
      if (cnt_q == FULL) ovf_d = 1'b1;
      else               cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= FULL;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/jbi_sc_req_ctl.sv
// Round-robin read/write request sequencer onto the 32-bit sctag request bus.
// Optional stall counters are built when JBI_SC_REQ_PERF_EN is defined.
module jbi_sc_req_ctl
  import jbi_sc_req_pkg::*;
#(
  parameter int IQ_DEPTH  = IQ_DEPTH_DEF,
  parameter int WIB_DEPTH = WIB_DEPTH_DEF,
  parameter int WR_BEATS  = WR_BEATS_DEF
) (
  input  logic                             rclk,
  input  logic                             arst_l,
  input  logic                             rd_req,
  input  logic [63:0]                      rd_hdr,
  output logic                             rd_gnt,
  input  logic                             wr_req,
  input  logic [63:0]                      wr_hdr,
  output logic                             wr_gnt,
  input  logic [31:0]                      wr_data,
  input  logic [6:0]                       wr_ecc,
  output logic                             wr_data_ack,
  input  logic                             sctag_jbi_iq_dequeue,
  input  logic                             sctag_jbi_wib_dequeue,
  input  logic                             sctag_jbi_por_req,
  output logic [31:0]                      jbi_sctag_req,
  output logic                             jbi_sctag_req_vld,
  output logic [6:0]                       jbi_scbuf_ecc,
  output logic                             por_done,
  output logic                             credit_err,
`ifdef JBI_SC_REQ_PERF_EN
  output logic [31:0]                      iq_stall_cnt,
  output logic [31:0]                      wib_stall_cnt,
`endif
  output logic [$clog2(IQ_DEPTH+1)-1:0]    iq_credit,
  output logic [$clog2(WIB_DEPTH+1)-1:0]   wib_credit
);

  localparam int IQW  = $clog2(IQ_DEPTH + 1);
  localparam int WIBW = $clog2(WIB_DEPTH + 1);
  // Beat counter is sized for the longest packet on the bus.
  localparam int BCW  = $clog2(HDR_BEATS + WR_BEATS);
  localparam logic [BCW-1:0]  LAST_BEAT = BCW'(WR_BEATS);
  localparam logic [IQW-1:0]  IQ_FULL   = IQW'(IQ_DEPTH);
  localparam logic [WIBW-1:0] WIB_FULL  = WIBW'(WIB_DEPTH);

  req_state_e     state_q, state_d;
  logic [31:0]    hdr_lo_q, hdr_lo_d;
  logic           is_wr_q, is_wr_d;
  logic           pref_wr_q, pref_wr_d;
  logic           por_pend_q, por_pend_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [31:0]    req_q, req_d;
  logic           vld_q, vld_d;
  logic [6:0]     ecc_q, ecc_d;

  logic iq_ok, wib_ok, rd_elig, wr_elig, pick_wr, any_gnt;
  logic iq_ovf, wib_ovf;

  assign iq_ok   = (iq_credit != '0);
  assign wib_ok  = (wib_credit != '0);
  assign rd_elig = rd_req && iq_ok;
  assign wr_elig = wr_req && iq_ok && wib_ok;
  assign pick_wr = wr_elig && (!rd_elig || pref_wr_q);
  assign any_gnt = rd_gnt || wr_gnt;

  always_comb begin
    state_d     = state_q;
    hdr_lo_d    = hdr_lo_q;
    is_wr_d     = is_wr_q;
    pref_wr_d   = pref_wr_q;
    por_pend_d  = por_pend_q || sctag_jbi_por_req;
    beat_d      = beat_q;
    req_d       = '0;
    vld_d       = 1'b0;
    ecc_d       = '0;
    rd_gnt      = 1'b0;
    wr_gnt      = 1'b0;
    wr_data_ack = 1'b0;
    por_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (por_pend_q) begin
          state_d = POR_DRAIN;
        end else if (rd_elig || wr_elig) begin
          rd_gnt    = !pick_wr;
          wr_gnt    = pick_wr;
          is_wr_d   = pick_wr;
          pref_wr_d = !pick_wr;
          req_d     = pick_wr ? wr_hdr[63:32] : rd_hdr[63:32];
          hdr_lo_d  = pick_wr ? wr_hdr[31:0]  : rd_hdr[31:0];
          vld_d     = 1'b1;
          state_d   = HDR_HI;
        end
      end
      HDR_HI: begin
        req_d   = hdr_lo_q;
        state_d = HDR_LO;
      end
      HDR_LO: begin
        if (is_wr_q) begin
          wr_data_ack = 1'b1;
          req_d       = wr_data;
          ecc_d       = wr_ecc;
          beat_d      = BCW'(1);
          state_d     = WR_DATA;
        end else begin
          state_d = IDLE;
        end
      end
      WR_DATA: begin
        if (beat_q < LAST_BEAT) begin
          wr_data_ack = 1'b1;
          req_d       = wr_data;
          ecc_d       = wr_ecc;
          beat_d      = beat_q + BCW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      POR_DRAIN: begin
        if (iq_credit == IQ_FULL && wib_credit == WIB_FULL) begin
          por_done   = 1'b1;
          por_pend_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q    <= IDLE;
      hdr_lo_q   <= '0;
      is_wr_q    <= 1'b0;
      pref_wr_q  <= 1'b0;
      por_pend_q <= 1'b0;
      beat_q     <= '0;
      req_q      <= '0;
      vld_q      <= 1'b0;
      ecc_q      <= '0;
    end else begin
      state_q    <= state_d;
      hdr_lo_q   <= hdr_lo_d;
      is_wr_q    <= is_wr_d;
      pref_wr_q  <= pref_wr_d;
      por_pend_q <= por_pend_d;
      beat_q     <= beat_d;
      req_q      <= req_d;
      vld_q      <= vld_d;
      ecc_q      <= ecc_d;
    end
  end

  assign jbi_sctag_req     = req_q;
  assign jbi_sctag_req_vld = vld_q;
  assign jbi_scbuf_ecc     = ecc_q;
  assign credit_err        = iq_ovf || wib_ovf;

  jbi_sc_credit_cnt #(.DEPTH(IQ_DEPTH)) u_iq_credit (
    .clk        (rclk),
    .rst_n      (arst_l),
    .inc_i      (sctag_jbi_iq_dequeue),
    .dec_i      (any_gnt),
    .count_o    (iq_credit),
    .overflow_o (iq_ovf)
  );

  jbi_sc_credit_cnt #(.DEPTH(WIB_DEPTH)) u_wib_credit (
    .clk        (rclk),
    .rst_n      (arst_l),
    .inc_i      (sctag_jbi_wib_dequeue),
    .dec_i      (wr_gnt),
    .count_o    (wib_credit),
    .overflow_o (wib_ovf)
  );

`ifdef JBI_SC_REQ_PERF_EN
  logic [31:0] iq_stall_q, wib_stall_q;
  logic        in_idle;

  assign in_idle = (state_q == IDLE);

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      iq_stall_q  <= '0;
      wib_stall_q <= '0;
    end else begin
      if (in_idle && (rd_req || wr_req) && !iq_ok) iq_stall_q <= iq_stall_q + 32'd1;
      if (in_idle && wr_req && iq_ok && !wib_ok)   wib_stall_q <= wib_stall_q + 32'd1;
    end
  end

  assign iq_stall_cnt  = iq_stall_q;
  assign wib_stall_cnt = wib_stall_q;
`endif

endmodule

// File: tb/tb_jbi_sc_req_ctl.sv
// Bench for jbi_sc_req_ctl: packet-level reference model plus directed and random stimulus.
module tb_jbi_sc_req_ctl;

  localparam int IQ_D  = 16;
  localparam int WIB_D = 4;
  localparam int WR_B  = 16;

  logic        rclk = 1'b0;
  logic        arst_l;
  logic        rd_req, wr_req;
  logic [63:0] rd_hdr, wr_hdr;
  logic        rd_gnt, wr_gnt, wr_data_ack;
  logic [31:0] wr_data;
  logic [6:0]  wr_ecc;
  logic        iq_deq, wib_deq, por_req;
  logic [31:0] req;
  logic        req_vld;
  logic [6:0]  ecc;
  logic        por_done, credit_err;
  logic [4:0]  iq_credit;
  logic [2:0]  wib_credit;
`ifdef JBI_SC_REQ_PERF_EN
  logic [31:0] iq_stall_cnt, wib_stall_cnt;
`endif

  jbi_sc_req_ctl dut (
    .rclk                  (rclk),
    .arst_l                (arst_l),
    .rd_req                (rd_req),
    .rd_hdr                (rd_hdr),
    .rd_gnt                (rd_gnt),
    .wr_req                (wr_req),
    .wr_hdr                (wr_hdr),
    .wr_gnt                (wr_gnt),
    .wr_data               (wr_data),
    .wr_ecc                (wr_ecc),
    .wr_data_ack           (wr_data_ack),
    .sctag_jbi_iq_dequeue  (iq_deq),
    .sctag_jbi_wib_dequeue (wib_deq),
    .sctag_jbi_por_req     (por_req),
    .jbi_sctag_req         (req),
    .jbi_sctag_req_vld     (req_vld),
    .jbi_scbuf_ecc         (ecc),
    .por_done              (por_done),
    .credit_err            (credit_err),
`ifdef JBI_SC_REQ_PERF_EN
    .iq_stall_cnt          (iq_stall_cnt),
    .wib_stall_cnt         (wib_stall_cnt),
`endif
    .iq_credit             (iq_credit),
    .wib_credit            (wib_credit)
  );

  always #5 rclk = ~rclk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Write-data source: show-ahead words popped by wr_data_ack.
  logic [31:0] words[4096];
  logic [6:0]  eccs[4096];
  bit   [11:0] wr_ptr;
  assign wr_data = words[wr_ptr];
  assign wr_ecc  = eccs[wr_ptr];

  always @(posedge rclk or negedge arst_l) begin
    if (!arst_l)          wr_ptr <= '0;
    else if (wr_data_ack) wr_ptr <= wr_ptr + 12'd1;
  end

  // Reference model: a queue of bus beats still to appear, plus credit arithmetic.
  typedef struct {
    logic [31:0] d;
    logic        v;
    logic [6:0]  e;
    bit          dat;
  } beat_t;

  beat_t       expq[$];
  beat_t       shown;
  int          m_iq, m_wib;
  bit          m_err, m_pend, m_drain, m_pref_wr;
  bit   [11:0] mdx;

  task automatic model_reset();
    expq.delete();
    shown     = '{d: '0, v: 1'b0, e: '0, dat: 1'b0};
    m_iq      = IQ_D;
    m_wib     = WIB_D;
    m_err     = 1'b0;
    m_pend    = 1'b0;
    m_drain   = 1'b0;
    m_pref_wr = 1'b0;
    mdx       = '0;
  endtask

  task automatic model_cycle();
    bit free, ack, rd_el, wr_el, g_rd, g_wr, done;
    logic [63:0] h;
    beat_t b;
    free  = (expq.size() == 0);
    ack   = !free && expq[0].dat;
    rd_el = rd_req && m_iq > 0;
    wr_el = wr_req && m_iq > 0 && m_wib > 0;
    g_rd  = 1'b0;
    g_wr  = 1'b0;
    done  = 1'b0;
    if (free && m_drain) begin
      done = (m_iq == IQ_D) && (m_wib == WIB_D);
    end else if (free && !m_pend) begin
      if (rd_el && wr_el) begin
        g_wr = m_pref_wr;
        g_rd = !m_pref_wr;
      end else begin
        g_rd = rd_el;
        g_wr = wr_el;
      end
    end

    chk("rd_gnt", 64'(rd_gnt), 64'(g_rd));
    chk("wr_gnt", 64'(wr_gnt), 64'(g_wr));
    chk("wr_data_ack", 64'(wr_data_ack), 64'(ack));
    chk("por_done", 64'(por_done), 64'(done));
    chk("bus", 64'(req), 64'(shown.d));
    chk("bus_vld", 64'(req_vld), 64'(shown.v));
    chk("bus_ecc", 64'(ecc), 64'(shown.e));
    chk("iq_credit", 64'(iq_credit), 64'(m_iq));
    chk("wib_credit", 64'(wib_credit), 64'(m_wib));
    chk("credit_err", 64'(credit_err), 64'(m_err));

    if (g_rd || g_wr) begin
      m_pref_wr = g_rd;
      h = g_wr ? wr_hdr : rd_hdr;
      expq.push_back('{d: h[63:32], v: 1'b1, e: '0, dat: 1'b0});
      expq.push_back('{d: h[31:0],  v: 1'b0, e: '0, dat: 1'b0});
      if (g_wr) begin
        for (int k = 0; k < WR_B; k++) begin
          expq.push_back('{d: words[mdx], v: 1'b0, e: eccs[mdx], dat: 1'b1});
          mdx++;
        end
      end
      expq.push_back('{d: '0, v: 1'b0, e: '0, dat: 1'b0});
    end
    if (free && !m_drain && m_pend) m_drain = 1'b1;
    if (done) m_drain = 1'b0;
    m_pend = (m_pend || por_req) && !done;

    if (iq_deq && !(g_rd || g_wr)) begin
      if (m_iq == IQ_D) m_err = 1'b1;
      else              m_iq++;
    end else if (!iq_deq && (g_rd || g_wr)) m_iq--;
    if (wib_deq && !g_wr) begin
      if (m_wib == WIB_D) m_err = 1'b1;
      else                m_wib++;
    end else if (!wib_deq && g_wr) m_wib--;

    if (expq.size() > 0) shown = expq.pop_front();
    else shown = '{d: '0, v: 1'b0, e: '0, dat: 1'b0};
  endtask

  always @(negedge rclk) begin
    if (!arst_l) model_reset();
    else         model_cycle();
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    iq_deq  = 1'b0;
    wib_deq = 1'b0;
    por_req = 1'b0;
  endtask

  task automatic reset_dut();
    arst_l = 1'b0;
    idle_inputs();
    repeat (2) tick();
    arst_l = 1'b1;
    tick();
  endtask

  int order[$];
  int cnt, nwr;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      words[i] = (i < 16) ? 32'(i) : $urandom;
      eccs[i]  = (i < 16) ? 7'(i) : 7'($urandom_range(0, 127));
    end
    rd_hdr = '0;
    wr_hdr = '0;
    arst_l = 1'b0;
    idle_inputs();
    repeat (2) tick();
    chk("rst_bus", 64'(req), 64'h0);
    chk("rst_vld", 64'(req_vld), 64'h0);
    chk("rst_iq", 64'(iq_credit), 64'd16);
    chk("rst_wib", 64'(wib_credit), 64'd4);
    chk("rst_err", 64'(credit_err), 64'h0);
    arst_l = 1'b1;
    tick();

    // Single read.
    rd_req = 1'b1;
    rd_hdr = 64'hAAAA_0001_5555_0002;
    #2 chk("rd1_gnt", 64'(rd_gnt), 64'h1);
    tick();
    rd_req = 1'b0;
    chk("rd1_hi", 64'(req), 64'hAAAA0001);
    chk("rd1_hi_vld", 64'(req_vld), 64'h1);
    chk("rd1_iq", 64'(iq_credit), 64'd15);
    tick();
    chk("rd1_lo", 64'(req), 64'h55550002);
    chk("rd1_lo_vld", 64'(req_vld), 64'h0);
    tick();
    chk("rd1_idle", 64'(req), 64'h0);

    // Single write with data 0..15.
    wr_req = 1'b1;
    wr_hdr = 64'h1234_5678_9ABC_DEF0;
    #2 chk("wr1_gnt", 64'(wr_gnt), 64'h1);
    tick();
    wr_req = 1'b0;
    chk("wr1_hi", 64'(req), 64'h12345678);
    chk("wr1_wib", 64'(wib_credit), 64'd3);
    repeat (17) tick();
    chk("wr1_last", 64'(req), 64'd15);
    chk("wr1_last_ecc", 64'(ecc), 64'd15);
    tick();
    chk("wr1_idle", 64'(req), 64'h0);
    chk("wr1_acks", 64'(wr_ptr), 64'd16);

    // Both requesting continuously from reset.
    reset_dut();
    rd_req = 1'b1;
    wr_req = 1'b1;
    order.delete();
    for (int c = 0; c < 120; c++) begin
      #2;
      if (rd_gnt) order.push_back(0);
      if (wr_gnt) order.push_back(1);
      tick();
    end
    idle_inputs();
    nwr = 0;
    foreach (order[i]) nwr += order[i];
    chk("rr_n", 64'(order.size() >= 9), 64'h1);
    chk("rr_0", 64'(order[0]), 64'd0);
    chk("rr_1", 64'(order[1]), 64'd1);
    chk("rr_2", 64'(order[2]), 64'd0);
    chk("rr_3", 64'(order[3]), 64'd1);
    chk("rr_8", 64'(order[8]), 64'd0);
    chk("rr_nwr", 64'(nwr), 64'd4);
    chk("rr_wib", 64'(wib_credit), 64'd0);
`ifdef JBI_SC_REQ_PERF_EN
    chk("rr_wib_stall", 64'(wib_stall_cnt != 0), 64'h1);
`endif
    repeat (20) tick();

    // Exhaust IQ credits with reads.
    reset_dut();
    rd_req = 1'b1;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      #2;
      if (rd_gnt) cnt++;
      tick();
    end
    chk("iq_reads", 64'(cnt), 64'd16);
    chk("iq_zero", 64'(iq_credit), 64'd0);
    #2 chk("iq_17th", 64'(rd_gnt), 64'h0);
    tick();
    iq_deq = 1'b1;
    tick();
    #2 chk("iq_regnt", 64'(rd_gnt), 64'h1);
    tick();
    iq_deq = 1'b0;
    rd_req = 1'b0;
    chk("iq_simul", 64'(iq_credit), 64'd1);
    repeat (5) tick();

    // POR request in the middle of a write.
    reset_dut();
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    tick();
    por_req = 1'b1;
    tick();
    por_req = 1'b0;
    rd_req = 1'b1;
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      #2;
      if (rd_gnt || wr_gnt) cnt++;
      tick();
    end
    chk("por_nogrant", 64'(cnt), 64'd0);
    chk("por_iq", 64'(iq_credit), 64'd15);
    chk("por_wib", 64'(wib_credit), 64'd3);
    iq_deq = 1'b1;
    tick();
    iq_deq = 1'b0;
    tick();
    wib_deq = 1'b1;
    #2 chk("por_early", 64'(por_done), 64'h0);
    tick();
    wib_deq = 1'b0;
    #2 chk("por_done", 64'(por_done), 64'h1);
    tick();
    #2 chk("por_pulse", 64'(por_done), 64'h0);
    chk("por_regnt", 64'(rd_gnt), 64'h1);
    tick();
    rd_req = 1'b0;
    repeat (4) tick();

    // Extra return at full, then async reset mid-packet.
    reset_dut();
    iq_deq = 1'b1;
    tick();
    iq_deq = 1'b0;
    chk("ovf_iq", 64'(iq_credit), 64'd16);
    chk("ovf_err", 64'(credit_err), 64'h1);
    repeat (3) tick();
    chk("ovf_sticky", 64'(credit_err), 64'h1);
    rd_req = 1'b1;
    rd_hdr = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    rd_req = 1'b0;
    chk("arst_pre", 64'(req), 64'hDEADBEEF);
    #2 arst_l = 1'b0;
    #1;
    chk("arst_bus", 64'(req), 64'h0);
    chk("arst_vld", 64'(req_vld), 64'h0);
    chk("arst_ecc", 64'(ecc), 64'h0);
    chk("arst_err", 64'(credit_err), 64'h0);
    chk("arst_iq", 64'(iq_credit), 64'd16);
    chk("arst_gnt", 64'({rd_gnt, wr_gnt, wr_data_ack, por_done}), 64'h0);
    tick();
    tick();
    arst_l = 1'b1;
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rd_req  = ($urandom_range(0, 3) != 0);
      wr_req  = ($urandom_range(0, 2) == 0);
      rd_hdr  = {$urandom, $urandom};
      wr_hdr  = {$urandom, $urandom};
      iq_deq  = ($urandom_range(0, 3) == 0);
      wib_deq = ($urandom_range(0, 15) == 0);
      por_req = ($urandom_range(0, 299) == 0);
      tick();
    end
    idle_inputs();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jbi_sc_req_ctl.md
Name: jbi_sc_req_ctl

Overview:
- Sequences JBI-to-L2 requests onto the 32-bit request bus into the sctag/scbuf slice. This bus is the one that passes through the JBI/SC2 repeater flop stage.
- Arbitrates round-robin between a read-request source and a write-request source.
- Serialises each packet into 32-bit beats and tracks sctag IQ and WIB credits from the dequeue pulses.
- Handles the sctag power-on-reset drain handshake.

Parameters:
- IQ_DEPTH, 16, sctag input-queue entries; every packet costs one IQ credit.
- WIB_DEPTH, 4, sctag write-invalidate-buffer entries; every write also costs one WIB credit.
- WR_BEATS, 16, 32-bit data beats per write packet (64B line).

Ports:
- rclk  in  1  clock
- arst_l  in  1  reset, asynchronous assert, active-low
- rd_req  in  1  read packet pending
- rd_hdr  in  64  read header; sampled when rd_gnt=1
- rd_gnt  out  1  combinational grant; requester advances next cycle
- wr_req  in  1  write packet pending
- wr_hdr  in  64  write header; sampled when wr_gnt=1
- wr_gnt  out  1  combinational grant
- wr_data  in  32  show-ahead write data word
- wr_ecc  in  7  ECC for wr_data
- wr_data_ack  out  1  combinational pop; wr_data/wr_ecc sampled this cycle
- sctag_jbi_iq_dequeue  in  1  pulse: return one IQ credit
- sctag_jbi_wib_dequeue  in  1  pulse: return one WIB credit
- sctag_jbi_por_req  in  1  pulse: request drain for POR
- jbi_sctag_req  out  32  registered request beat
- jbi_sctag_req_vld  out  1  registered; high on first beat only
- jbi_scbuf_ecc  out  7  registered; ECC on data beats, 0 otherwise
- por_done  out  1  one-cycle pulse, drain complete
- credit_err  out  1  sticky; a credit was returned while the counter was already full
- iq_credit  out  clog2(IQ_DEPTH+1)  current IQ credits
- wib_credit  out  clog2(WIB_DEPTH+1)  current WIB credits

Behaviour:
- Reset values:
  - State IDLE; all bus outputs 0; gnt/ack/por_done 0; credit_err 0.
  - iq_credit=IQ_DEPTH, wib_credit=WIB_DEPTH.
  - Arbitration pointer prefers read; por_pend=0.
- Eligibility:
  - Read is eligible when rd_req && iq_credit>0.
  - Write is eligible when wr_req && iq_credit>0 && wib_credit>0.
- Grants:
  - Grants are issued only in IDLE with por_pend=0.
  - If both are eligible, the pointer decides. If one is eligible, it wins.
  - After any grant, the pointer is set to favour the other source.
- Grant cycle T: capture the header; decrement iq_credit (and wib_credit for a write); next state HDR_HI.
- HDR_HI (T+1): bus=hdr[63:32], vld=1, ecc=0; next HDR_LO.
- HDR_LO (T+2): bus=hdr[31:0], vld=0.
  - Read: next IDLE.
  - Write: assert wr_data_ack, load the first data word into the output registers, beat_cnt=1, next WR_DATA.
- WR_DATA:
  - Bus shows the data beat with its ECC.
  - If beat_cnt<WR_BEATS: ack, load next word, increment beat_cnt.
  - Else load 0 and go to IDLE.
  - Total acks per write = WR_BEATS.
- Packet lengths: read = 2 bus beats; write = 2+WR_BEATS.
- One idle bus cycle always follows a packet: bus=0, vld=0.
- Credit counters:
  - Same-cycle consume and return leave the count unchanged.
  - A return at full count saturates and sets credit_err.
  - A consume at 0 cannot occur by construction.
- POR:
  - A sctag_jbi_por_req pulse sets registered por_pend.
  - A grant in the same cycle as the pulse is still issued.
  - An in-flight packet always completes.
  - In IDLE with por_pend: go to POR_DRAIN; no grants.
  - Exit POR_DRAIN when iq_credit==IQ_DEPTH && wib_credit==WIB_DEPTH: pulse por_done for one cycle, clear por_pend, return to IDLE.
  - Further por_req pulses while pending are absorbed.
- Async reset mid-packet aborts immediately to reset values; partial packets are not replayed.

Optional Feature:
- Macro: JBI_SC_REQ_PERF_EN
- With the macro: adds outputs iq_stall_cnt[31:0] and wib_stall_cnt[31:0], both wrapping.
  - iq_stall_cnt increments each IDLE cycle where a request is pending but blocked by iq_credit==0.
  - wib_stall_cnt increments when wr_req is blocked only by wib_credit==0.
  - Both reset to 0.
- Without the macro: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package jbi_sc_req_pkg holds:
  - the state enum (IDLE, HDR_HI, HDR_LO, WR_DATA, POR_DRAIN);
  - the header beat count (2);
  - the default credit depths.
- Sub-module jbi_sc_credit_cnt (parameter DEPTH; inc/dec/count/overflow), instantiated twice, for IQ and WIB.

Test Plan:
- Single read, rd_hdr=64'hAAAA_0001_5555_0002:
  - rd_gnt at T; T+1 bus=AAAA0001 with vld=1; T+2 bus=55550002 with vld=0; T+3 bus=0.
  - iq_credit goes 16->15.
- Single write, WR_BEATS=16, data words 0..15, ecc=word[6:0]:
  - Exactly 16 wr_data_ack pulses; 18 bus beats; ecc nonzero only on data beats.
  - wib_credit goes 4->3.
- Rd and wr requesting continuously from reset:
  - Grant order rd, wr, rd, wr.
  - After 4 writes without WIB dequeue, only reads are granted; wib_stall_cnt increments (PERF_EN).
- 16 reads without dequeue:
  - 17th read not granted; iq_credit=0.
  - One iq_dequeue pulse -> grant the following cycle.
  - Simultaneous grant and dequeue keep the count at 1.
- por_req mid-write:
  - Write completes; no new grant.
  - por_done pulses the cycle after the final iq and wib dequeues restore 16/4.
- Extra iq_dequeue at iq_credit=16:
  - Count stays 16; credit_err=1 until reset.
  - Assert arst_l low mid-packet -> all outputs 0 immediately.
